// File: rtl/sine_table_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sine_table_loader_pkg
//  Description : Shared definitions for the sine table loader: default table
//                geometry, the loader state encoding and a state decode
//                helper. Optional feature macro used by the loader:
//                SINE_TABLE_LOADER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package sine_table_loader_pkg;

    localparam int SINE_TABLE_ADDR_WIDTH = 14;
    localparam int SINE_TABLE_DATA_WIDTH = 16;

    // CHECK_* states are only reachable when the checksum trailer is enabled.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOW_BYTE   = 3'd1,
        ST_HIGH_BYTE  = 3'd2,
        ST_WRITE      = 3'd3,
        ST_CHECK_LOW  = 3'd4,
        ST_CHECK_HIGH = 3'd5,
        ST_DONE       = 3'd6
    } loader_state_t;

    // States in which the loader is willing to take a stream byte.
    function automatic logic is_byte_ready_state(input loader_state_t s);
        return (s == ST_LOW_BYTE)  || (s == ST_HIGH_BYTE) ||
               (s == ST_CHECK_LOW) || (s == ST_CHECK_HIGH);
    endfunction

endpackage : sine_table_loader_pkg
`default_nettype wire

// File: rtl/sine_table_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : sine_table_loader_if
//  Description : Byte stream handshake into the sine table loader.
//                Signal names are relative to the loader.
//  Ports       : i_ByteValid - byte present on i_Byte
//                i_Byte      - stream byte, low byte of each word first
//                o_ByteReady - loader accepts the byte this cycle
//  Modports    : master - byte source, slave - loader
//  Revision    : 1.0 - initial release
// ============================================================================
interface sine_table_loader_if;
    logic       i_ByteValid;
    logic [7:0] i_Byte;
    logic       o_ByteReady;

    modport master (output i_ByteValid, output i_Byte, input  o_ByteReady);
    modport slave  (input  i_ByteValid, input  i_Byte, output o_ByteReady);
endinterface : sine_table_loader_if
`default_nettype wire

// File: rtl/sine_table_loader_byte_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_assembler
//  Description : Pairs consecutive accepted bytes (low first) into a 16-bit
//                word. o_WordValid pulses combinationally in the cycle the
//                high byte is accepted, with o_Word = {high, stored low}.
//  Ports       : i_Clock, i_Reset_n (sync, active-low)
//                i_Clear     - drop any stored half word
//                i_ByteFire  - a byte is transferred this cycle
//                i_Byte      - the transferred byte
//                o_WordValid - a complete word is available this cycle
//                o_Word      - the assembled word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_word_assembler (
    input  wire logic        i_Clock,
    input  wire logic        i_Reset_n,
    input  wire logic        i_Clear,
    input  wire logic        i_ByteFire,
    input  wire logic [7:0]  i_Byte,
    output logic             o_WordValid,
    output logic [15:0]      o_Word
);

    logic       high_phase_q;
    logic [7:0] low_q;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            high_phase_q <= 1'b0;
            low_q        <= 8'h00;
        end else if (i_Clear) begin
            high_phase_q <= 1'b0;
        end else if (i_ByteFire) begin
            if (!high_phase_q) begin
                low_q <= i_Byte;
            end
            high_phase_q <= ~high_phase_q;
        end
    end

    assign o_WordValid = i_ByteFire && high_phase_q && !i_Clear;
    assign o_Word      = {i_Byte, low_q};

endmodule : byte_word_assembler
`default_nettype wire

// File: rtl/sine_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sine_table_loader
//  Description : Loads a waveform generator sine table from a little-endian
//                byte stream. Each word produces a one-cycle registered write
//                strobe; addresses run 0 .. 2**ADDR_WIDTH-1 in order.
//                i_Start (re)starts a load at any time.
//  Option      : `define SINE_TABLE_LOADER_CHECKSUM_EN to expect a trailing
//                16-bit checksum word (mod 2**16 sum of all table words);
//                o_ChecksumError reports a mismatch. Without it the last
//                write goes straight to DONE and o_ChecksumError is 0.
//  Ports       : i_Clock, i_Reset_n (sync, active-low), i_Start
//                byte_if (slave)          - byte stream handshake
//                o_SineTableWriteEnable   - table write strobe
//                o_SineTableWriteAddress  - table index of the strobe
//                o_SineTableWriteValue    - table word of the strobe
//                o_Busy, o_Done, o_ChecksumError - load status
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_table_loader
    import sine_table_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = SINE_TABLE_ADDR_WIDTH,
    parameter int DATA_WIDTH = SINE_TABLE_DATA_WIDTH
) (
    input  wire logic                  i_Clock,
    input  wire logic                  i_Reset_n,
    input  wire logic                  i_Start,
    sine_table_loader_if.slave         byte_if,
    output logic                       o_SineTableWriteEnable,
    output logic [ADDR_WIDTH-1:0]      o_SineTableWriteAddress,
    output logic [DATA_WIDTH-1:0]      o_SineTableWriteValue,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic                       o_ChecksumError
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};

    loader_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]    cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    val_q, val_d;
    logic                     we_q, we_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;
    logic                     done_q, done_d;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    logic [15:0]              sum_q, sum_d;
    logic                     cserr_q, cserr_d;
`endif

    logic                     byte_fire;
    logic                     word_valid;
    logic [15:0]              word;

    // A byte coinciding with i_Start is never consumed: the restart wins.
    assign byte_fire = byte_if.i_ByteValid && ready_q && !i_Start;

    byte_word_assembler u_assembler (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Clear     (i_Start),
        .i_ByteFire  (byte_fire),
        .i_Byte      (byte_if.i_Byte),
        .o_WordValid (word_valid),
        .o_Word      (word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        val_d   = val_q;
        we_d    = 1'b0;
        done_d  = done_q;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        cserr_d = cserr_q;
`endif
        if (i_Start) begin
            state_d = ST_LOW_BYTE;
            cnt_d   = '0;
            done_d  = 1'b0;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
            sum_d   = 16'h0000;
            cserr_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOW_BYTE: begin
                    if (byte_fire) begin
                        state_d = ST_HIGH_BYTE;
                    end
                end
                ST_HIGH_BYTE: begin
                    // Strobe is registered, so it shows during WRITE.
                    if (word_valid) begin
                        state_d = ST_WRITE;
                        we_d    = 1'b1;
                        addr_d  = cnt_q;
                        val_d   = word;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + word;
`endif
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == c_LAST_ADDR) begin
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK_LOW;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_LOW_BYTE;
                    end
                end
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
                ST_CHECK_LOW: begin
                    if (byte_fire) begin
                        state_d = ST_CHECK_HIGH;
                    end
                end
                ST_CHECK_HIGH: begin
                    if (word_valid) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        cserr_d = (word != sum_q);
                    end
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end
        // Status outputs are registered from the next state.
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
        ready_d = is_byte_ready_state(state_d);
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            val_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
            sum_q   <= 16'h0000;
            cserr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            cserr_q <= cserr_d;
`endif
        end
    end

    assign byte_if.o_ByteReady     = ready_q;
    assign o_SineTableWriteEnable  = we_q;
    assign o_SineTableWriteAddress = addr_q;
    assign o_SineTableWriteValue   = val_q;
    assign o_Busy                  = busy_q;
    assign o_Done                  = done_q;
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    assign o_ChecksumError         = cserr_q;
`else
    assign o_ChecksumError         = 1'b0;
`endif

endmodule : sine_table_loader
`default_nettype wire

// File: tb/tb_sine_table_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sine_table_loader
//  Description : Self-checking bench for sine_table_loader. A default-size
//                instance (big) and a 16-entry instance (small) share the
//                clock and reset. Expected table writes are queued as words
//                are sent and popped by a strobe monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sine_table_loader;

    logic clk;
    logic rst_n;
    logic start_b;
    logic start_s;

    sine_table_loader_if ifb ();
    sine_table_loader_if ifs ();

    logic        b_we, b_busy, b_done, b_cserr;
    logic [13:0] b_addr;
    logic [15:0] b_val;
    logic        s_we, s_busy, s_done, s_cserr;
    logic [3:0]  s_addr;
    logic [15:0] s_val;

    int errors = 0;
    int checks = 0;
    logic [31:0] qb[$];
    logic [31:0] qs[$];
    logic [15:0] sum_b;
    logic [15:0] sum_s;

    sine_table_loader dut_big (
        .i_Clock                 (clk),
        .i_Reset_n               (rst_n),
        .i_Start                 (start_b),
        .byte_if                 (ifb),
        .o_SineTableWriteEnable  (b_we),
        .o_SineTableWriteAddress (b_addr),
        .o_SineTableWriteValue   (b_val),
        .o_Busy                  (b_busy),
        .o_Done                  (b_done),
        .o_ChecksumError         (b_cserr)
    );

    sine_table_loader #(.ADDR_WIDTH(4)) dut_small (
        .i_Clock                 (clk),
        .i_Reset_n               (rst_n),
        .i_Start                 (start_s),
        .byte_if                 (ifs),
        .o_SineTableWriteEnable  (s_we),
        .o_SineTableWriteAddress (s_addr),
        .o_SineTableWriteValue   (s_val),
        .o_Busy                  (s_busy),
        .o_Done                  (s_done),
        .o_ChecksumError         (s_cserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitors: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (b_we === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL big_unexpected_strobe: addr=%0d value=%h, none expected", b_addr, b_val);
            end else begin
                exp_w = qb.pop_front();
                if ({16'(b_addr), b_val} !== exp_w) begin
                    errors++;
                    $display("FAIL big_write: got addr=%0d value=%h, expected addr=%0d value=%h",
                             b_addr, b_val, exp_w[31:16], exp_w[15:0]);
                end
            end
        end
        if (s_we === 1'b1) begin
            checks++;
            if (qs.size() == 0) begin
                errors++;
                $display("FAIL small_unexpected_strobe: addr=%0d value=%h, none expected", s_addr, s_val);
            end else begin
                exp_w = qs.pop_front();
                if ({16'(s_addr), s_val} !== exp_w) begin
                    errors++;
                    $display("FAIL small_write: got addr=%0d value=%h, expected addr=%0d value=%h",
                             s_addr, s_val, exp_w[31:16], exp_w[15:0]);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- drivers
    task automatic set_valid(input bit sel, input logic v, input logic [7:0] b);
        if (sel) begin ifs.i_ByteValid = v; ifs.i_Byte = b; end
        else     begin ifb.i_ByteValid = v; ifb.i_Byte = b; end
    endtask

    task automatic idle(input bit sel, input int n);
        repeat (n) begin
            @(negedge clk);
            set_valid(sel, 1'b0, 8'h00);
        end
    endtask

    // Offer one byte and return right after the edge that transfers it.
    task automatic drive_byte(input bit sel, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        set_valid(sel, 1'b1, b);
        while ((sel ? ifs.o_ByteReady : ifb.o_ByteReady) !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: ready=0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic send_word(input bit sel, input int idx, input logic [15:0] w, input int maxgap);
        if (sel) begin qs.push_back({16'(idx), w}); sum_s = sum_s + w; end
        else     begin qb.push_back({16'(idx), w}); sum_b = sum_b + w; end
        idle(sel, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        drive_byte(sel, w[7:0]);
        idle(sel, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        drive_byte(sel, w[15:8]);
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        set_valid(sel, 1'b0, 8'h00);
        if (sel) begin start_s = 1'b1; sum_s = 16'h0000; end
        else     begin start_b = 1'b1; sum_b = 16'h0000; end
        @(negedge clk);
        start_s = 1'b0;
        start_b = 1'b0;
    endtask

    // Covers the WRITE cycle of the last word (and the trailer if enabled);
    // returns at the negedge where DONE should be visible.
    task automatic finish_load(input bit sel);
        @(negedge clk);
        set_valid(sel, 1'b0, 8'h00);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        drive_byte(sel, sel ? sum_s[7:0]  : sum_b[7:0]);
        drive_byte(sel, sel ? sum_s[15:8] : sum_b[15:8]);
`endif
        @(negedge clk);
        set_valid(sel, 1'b0, 8'h00);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b_we, b_busy, b_done, b_cserr, ifb.o_ByteReady, b_addr, b_val} !== 35'd0) begin
            errors++;
            $display("FAIL reset_big: got we=%b busy=%b done=%b cserr=%b ready=%b addr=%0d value=%h, expected all 0",
                     b_we, b_busy, b_done, b_cserr, ifb.o_ByteReady, b_addr, b_val);
        end
        checks++;
        if ({s_we, s_busy, s_done, s_cserr, ifs.o_ByteReady, s_addr, s_val} !== 25'd0) begin
            errors++;
            $display("FAIL reset_small: got we=%b busy=%b done=%b cserr=%b ready=%b addr=%0d value=%h, expected all 0",
                     s_we, s_busy, s_done, s_cserr, ifs.o_ByteReady, s_addr, s_val);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        pulse_start(0);
        checks++;
        if (b_busy !== 1'b1 || ifb.o_ByteReady !== 1'b1) begin
            errors++;
            $display("FAIL full_start: got busy=%b ready=%b, expected 1 1", b_busy, ifb.o_ByteReady);
        end
        for (int i = 0; i < 16384; i++) send_word(0, i, 16'(i) ^ 16'h5A5A, 0);
        finish_load(0);
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || ifb.o_ByteReady !== 1'b0) begin
            errors++;
            $display("FAIL full_done: got done=%b busy=%b ready=%b, expected 1 0 0", b_done, b_busy, ifb.o_ByteReady);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (qb.size() != 0 || b_done !== 1'b1) begin
            errors++;
            $display("FAIL full_all_written: got pending=%0d done=%b, expected 0 1", qb.size(), b_done);
        end
    endtask

    task automatic test_abort();
        pulse_start(0);
        checks++;
        if (b_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_cleared: got done=%b, expected 0", b_done);
        end
        for (int i = 0; i < 100; i++) send_word(0, i, 16'(i) ^ 16'h1234, 0);
        drive_byte(0, 8'hEE);          // low byte of address 100 only
        pulse_start(0);
        for (int i = 0; i < 4; i++) send_word(0, i, 16'(i) ^ 16'hA5A5, 0);
        @(negedge clk);
        set_valid(0, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (qb.size() != 0 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got pending=%0d busy=%b, expected 0 1", qb.size(), b_busy);
        end
    endtask

    task automatic test_reset_in_write();
        pulse_start(0);
        for (int i = 0; i < 8; i++) send_word(0, i, 16'(i) + 16'h8000, 0);
        @(negedge clk);                 // WRITE cycle of address 7
        set_valid(0, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({b_we, b_busy, b_done, b_cserr, ifb.o_ByteReady, b_addr, b_val} !== 35'd0) begin
            errors++;
            $display("FAIL reset_in_write: got we=%b busy=%b done=%b cserr=%b ready=%b addr=%0d value=%h, expected all 0",
                     b_we, b_busy, b_done, b_cserr, ifb.o_ByteReady, b_addr, b_val);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (b_busy !== 1'b0 || qb.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b pending=%0d, expected 0 0", b_busy, qb.size());
        end
        pulse_start(0);
        for (int i = 0; i < 3; i++) send_word(0, i, 16'hC000 | 16'(i), 0);
        @(negedge clk);
        set_valid(0, 1'b0, 8'h00);
        @(negedge clk);
        checks++;
        if (qb.size() != 0 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_reload: got pending=%0d busy=%b, expected 0 1", qb.size(), b_busy);
        end
    endtask

    task automatic test_gaps();
        pulse_start(1);
        for (int i = 0; i < 16; i++) send_word(1, i, 16'($urandom), 5);
        finish_load(1);
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || qs.size() != 0) begin
            errors++;
            $display("FAIL gaps_done: got done=%b busy=%b pending=%0d, expected 1 0 0", s_done, s_busy, qs.size());
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(1);
        checks++;
        if (s_done !== 1'b0 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got done=%b busy=%b, expected 0 1", s_done, s_busy);
        end
        for (int i = 0; i < 16; i++) send_word(1, i, 16'hFFFF - 16'(i * 3), 0);
        finish_load(1);
        checks++;
        if (s_done !== 1'b1 || s_busy !== 1'b0 || ifs.o_ByteReady !== 1'b0 || s_cserr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got done=%b busy=%b ready=%b cserr=%b, expected 1 0 0 0",
                     s_done, s_busy, ifs.o_ByteReady, s_cserr);
        end
        set_valid(1, 1'b1, 8'h55);      // bytes offered after DONE stay unconsumed
        repeat (4) @(negedge clk);
        set_valid(1, 1'b0, 8'h00);
        checks++;
        if (ifs.o_ByteReady !== 1'b0 || s_done !== 1'b1 || qs.size() != 0) begin
            errors++;
            $display("FAIL b2b_hold: got ready=%b done=%b pending=%0d, expected 0 1 0",
                     ifs.o_ByteReady, s_done, qs.size());
        end
    endtask

`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [15:0] trailer, input logic exp_err);
        pulse_start(1);
        for (int i = 1; i <= 16; i++) send_word(1, i - 1, 16'(i), 0);
        @(negedge clk);
        set_valid(1, 1'b0, 8'h00);
        drive_byte(1, trailer[7:0]);
        drive_byte(1, trailer[15:8]);
        @(negedge clk);
        set_valid(1, 1'b0, 8'h00);
        checks++;
        if (s_done !== 1'b1 || s_cserr !== exp_err || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL checksum_%h: got done=%b cserr=%b busy=%b, expected 1 %b 0",
                     trailer, s_done, s_cserr, s_busy, exp_err);
        end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        start_b = 1'b0;
        start_s = 1'b0;
        sum_b   = 16'h0000;
        sum_s   = 16'h0000;
        set_valid(0, 1'b0, 8'h00);
        set_valid(1, 1'b0, 8'h00);
        test_reset();
        test_full_load();
        test_abort();
        test_reset_in_write();
        test_gaps();
        test_back_to_back();
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        test_checksum(16'h0088, 1'b0);
        test_checksum(16'h0089, 1'b1);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sine_table_loader
`default_nettype wire
